modulo_n_counter: RTL and testbench

Parametrised modulo-N up/down counter, successor to the fixed decade counter. Counts 0..MODULUS-1 in either direction with wrap-around and supports synchronous clear and parallel load. Provides a combinational terminal-count output for cascading stages, such as BCD digits or clock-divider chains, and a registered wrap pulse for status and interrupt logic.

---
 rtl/modulo_n_counter.sv | 116 +++++++++++
 tb/tb_modulo_n_counter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/modulo_n_counter.sv
// Parametrised modulo-N up/down counter with synchronous clear and load, a
// combinational terminal count for cascading, and a registered wrap pulse.
// Optional feature macro: MODCNT_LOAD_CHECK_EN. When it is defined, an
// out-of-range load is rejected and a sticky load_err flag is raised.
// When it is undefined, an out-of-range load is clamped to MODULUS-1.
module modulo_n_counter #(
  parameter  int unsigned MODULUS = 10,
  localparam int unsigned WIDTH   = $clog2(MODULUS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
`ifdef MODCNT_LOAD_CHECK_EN
  ,
  output logic             load_err
`endif
);

  // Compares run one bit wider than the count, so MODULUS-1 never aliases
  // when MODULUS is a power of two.
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH:0]   count_ext;
  logic [WIDTH:0]   load_ext;
  logic             at_max;
  logic             at_zero;
  logic             load_ok;
  logic             tc_int;

  assign count_ext = {1'b0, count_q};
  assign load_ext  = {1'b0, load_val};
  assign at_max    = (count_ext == MAX_EXT);
  assign at_zero   = (count_q == '0);
  assign load_ok   = (load_ext <= MAX_EXT);

  // Masked by clear and load, so a stage that is about to be overridden never
  // advances the stage above it.
  assign tc_int = enable & ~clear & ~load & ((up_dn & at_max) | (~up_dn & at_zero));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    count_d = count_q;
    wrap_d  = tc_int;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      if (load_ok) begin
        count_d = load_val;
      end else begin
`ifdef MODCNT_LOAD_CHECK_EN
        count_d = count_q;
`else
        count_d = MAX_VAL;
`endif
      end
    end else if (enable) begin
      if (up_dn) begin
        count_d = at_max ? '0 : count_q + WIDTH'(1);
      end else begin
        count_d = at_zero ? MAX_VAL : count_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef MODCNT_LOAD_CHECK_EN
  logic load_err_q, load_err_d;

  // Sticky until clear; a later legal load does not clear it.
  always_comb begin
    load_err_d = load_err_q;
    if (clear) begin
      load_err_d = 1'b0;
    end else if (load && !load_ok) begin
      load_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= load_err_d;
    end
  end

  assign load_err = load_err_q;
`endif

  assign count = count_q;
  assign tc    = tc_int;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_modulo_n_counter.sv
// Scoreboard bench for modulo_n_counter: MODULUS=10 and 16 instances plus a
// two-digit cascade; expected responses are queued and checked by a monitor.
module tb_modulo_n_counter;

`ifdef MODCNT_LOAD_CHECK_EN
  localparam bit LCHK = 1'b1;
`else
  localparam bit LCHK = 1'b0;
`endif

  logic clk;
  logic reset_n;

  logic       c10, l10, en10, ud10;
  logic [3:0] lv10;
  logic [3:0] cnt10;
  logic       tc10, wrap10;

  logic       en16, ud16;
  logic [3:0] cnt16;
  logic       tc16, wrap16;

  logic       en_c;
  logic [3:0] cnt_lo, cnt_hi;
  logic       tc_lo, tc_hi, wrap_lo, wrap_hi;

`ifdef MODCNT_LOAD_CHECK_EN
  logic lerr10, lerr16, lerr_lo, lerr_hi;
`endif

  modulo_n_counter #(.MODULUS(10)) u_m10 (
    .clk(clk), .reset_n(reset_n), .clear(c10), .load(l10), .load_val(lv10),
    .enable(en10), .up_dn(ud10), .count(cnt10), .tc(tc10), .wrap(wrap10)
`ifdef MODCNT_LOAD_CHECK_EN
    , .load_err(lerr10)
`endif
  );

  modulo_n_counter #(.MODULUS(16)) u_m16 (
    .clk(clk), .reset_n(reset_n), .clear(1'b0), .load(1'b0), .load_val(4'd0),
    .enable(en16), .up_dn(ud16), .count(cnt16), .tc(tc16), .wrap(wrap16)
`ifdef MODCNT_LOAD_CHECK_EN
    , .load_err(lerr16)
`endif
  );

  modulo_n_counter #(.MODULUS(10)) u_lo (
    .clk(clk), .reset_n(reset_n), .clear(1'b0), .load(1'b0), .load_val(4'd0),
    .enable(en_c), .up_dn(1'b1), .count(cnt_lo), .tc(tc_lo), .wrap(wrap_lo)
`ifdef MODCNT_LOAD_CHECK_EN
    , .load_err(lerr_lo)
`endif
  );

  modulo_n_counter #(.MODULUS(10)) u_hi (
    .clk(clk), .reset_n(reset_n), .clear(1'b0), .load(1'b0), .load_val(4'd0),
    .enable(tc_lo), .up_dn(1'b1), .count(cnt_hi), .tc(tc_hi), .wrap(wrap_hi)
`ifdef MODCNT_LOAD_CHECK_EN
    , .load_err(lerr_hi)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dut: 0 = MODULUS 10, 1 = MODULUS 16, 2 = cascade (count = hi*10+lo,
  // tc/wrap from the high stage, aux = low-stage wrap).
  typedef struct {
    int    dut;
    int    cnt;
    bit    tc;
    bit    wrap;
    bit    lerr;
    bit    aux;
    string name;
  } exp_t;

  exp_t sb[$];
  event smp_ev;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string nm, input int ac, input bit at, aw, al, ax,
                       input int ec, input bit et, ew, el, ex);
    n_tests++;
    if ({ac, at, aw, al, ax} !== {ec, et, ew, el, ex}) begin
      n_fail++;
      $display("FAIL %s: got count=%0d tc=%0b wrap=%0b load_err=%0b aux=%0b, expected count=%0d tc=%0b wrap=%0b load_err=%0b aux=%0b",
               nm, ac, at, aw, al, ax, ec, et, ew, el, ex);
    end
  endtask

  // Monitor: compares every queued expectation against the live outputs.
  initial begin
    exp_t e;
    int   ac;
    bit   at, aw, al, ax;
    forever begin
      @(negedge clk or smp_ev);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        al = 1'b0;
        case (e.dut)
          0: begin
            ac = int'(cnt10); at = tc10; aw = wrap10; ax = 1'b0;
`ifdef MODCNT_LOAD_CHECK_EN
            al = lerr10;
`endif
          end
          1: begin
            ac = int'(cnt16); at = tc16; aw = wrap16; ax = 1'b0;
`ifdef MODCNT_LOAD_CHECK_EN
            al = lerr16;
`endif
          end
          default: begin
            ac = int'(cnt_hi) * 10 + int'(cnt_lo); at = tc_hi; aw = wrap_hi; ax = wrap_lo;
`ifdef MODCNT_LOAD_CHECK_EN
            al = lerr_lo | lerr_hi;
`endif
          end
        endcase
        check(e.name, ac, at, aw, al, ax, e.cnt, e.tc, e.wrap, e.lerr, e.aux);
      end
    end
  end

  // Each step drives inputs just after a rising edge and queues the outputs
  // expected for the remainder of that cycle.
  task automatic step10(input bit c, l, input logic [3:0] lv, input bit en, ud,
                        input int ec, input bit et, ew, el, input string nm);
    @(posedge clk);
    #1;
    c10 = c; l10 = l; lv10 = lv; en10 = en; ud10 = ud;
    sb.push_back('{0, ec, et, ew, el, 1'b0, nm});
  endtask

  task automatic step16(input bit en, ud, input int ec, input bit et, ew, input string nm);
    @(posedge clk);
    #1;
    en16 = en; ud16 = ud;
    sb.push_back('{1, ec, et, ew, 1'b0, 1'b0, nm});
  endtask

  task automatic stepc(input bit en, input int ec, input bit et, ew, ex, input string nm);
    @(posedge clk);
    #1;
    en_c = en;
    sb.push_back('{2, ec, et, ew, 1'b0, ex, nm});
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    c10 = 1'b0; l10 = 1'b0; lv10 = 4'd0; en10 = 1'b0; ud10 = 1'b1;
    en16 = 1'b0; ud16 = 1'b1; en_c = 1'b0;

    @(posedge clk);
    #1;
    sb.push_back('{0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_m10"});
    sb.push_back('{1, 0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_m16"});
    sb.push_back('{2, 0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_casc"});
    #2 reset_n = 1'b1;

    for (int i = 0; i < 12; i++)
      step10(0, 0, 4'd0, 1, 1, i % 10, i == 9, i == 10, 0, "up_wrap");

    step10(1, 0, 4'd0, 1, 1, 2, 0, 0, 0, "clear");
    step10(0, 0, 4'd0, 1, 0, 0, 1, 0, 0, "down_tc0");
    step10(0, 0, 4'd0, 1, 0, 9, 0, 1, 0, "down_wrap9");
    step10(0, 0, 4'd0, 1, 0, 8, 0, 0, 0, "down_8");

    step10(1, 0, 4'd0, 0, 1, 7, 0, 0, 0, "clear_7");
    step10(0, 1, 4'd7, 1, 1, 0, 0, 0, 0, "load7");
    step10(0, 0, 4'd0, 1, 1, 7, 0, 0, 0, "after_load_7");
    step10(0, 0, 4'd0, 1, 1, 8, 0, 0, 0, "after_load_8");
    step10(0, 0, 4'd0, 1, 1, 9, 1, 0, 0, "after_load_9");
    step10(0, 0, 4'd0, 0, 1, 0, 0, 1, 0, "after_load_0");
    step10(0, 1, 4'd3, 1, 0, 0, 0, 0, 0, "load_over_tc");
    step10(1, 1, 4'd5, 1, 1, 3, 0, 0, 0, "clear_and_load");
    step10(0, 0, 4'd0, 0, 1, 0, 0, 0, 0, "clear_wins");

    step10(0, 1, 4'd12, 0, 1, 0, 0, 0, 0, "load12");
    step10(0, 0, 4'd0, 0, 1, LCHK ? 0 : 9, 0, 0, LCHK, "oor_result");
    step10(0, 1, 4'd4, 0, 1, LCHK ? 0 : 9, 0, 0, LCHK, "oor_sticky");
    step10(0, 0, 4'd0, 0, 1, 4, 0, 0, LCHK, "legal_load4");
    step10(1, 0, 4'd0, 0, 1, 4, 0, 0, LCHK, "clear_lerr");
    step10(0, 0, 4'd0, 0, 1, 0, 0, 0, 0, "lerr_cleared");

    for (int i = 0; i < 17; i++)
      step16(1, 1, i % 16, i == 15, i == 16, "m16_up_wrap");
    step16(1, 0, 1, 0, 0, "m16_down_1");
    step16(1, 0, 0, 1, 0, "m16_down_tc");
    step16(0, 1, 15, 0, 1, "m16_down_wrap");

    for (int i = 0; i <= 100; i++)
      stepc(1, i % 100, i == 99, i == 100, (i % 10 == 0) && (i != 0), "cascade");
    stepc(0, 1, 0, 0, 0, "cascade_hold");

    for (int i = 0; i < 6; i++)
      step10(0, 0, 4'd0, 1, 1, i, 0, 0, 0, "pre_reset");

    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    sb.push_back('{0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "async_reset_m10"});
    sb.push_back('{1, 0, 1'b0, 1'b0, 1'b0, 1'b0, "async_reset_m16"});
    sb.push_back('{2, 0, 1'b0, 1'b0, 1'b0, 1'b0, "async_reset_casc"});
    ->smp_ev;

    @(posedge clk);
    #1;
    sb.push_back('{0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_hold"});
    #2 reset_n = 1'b1;
    step10(0, 0, 4'd0, 1, 1, 1, 0, 0, 0, "resume_1");
    step10(0, 0, 4'd0, 0, 1, 2, 0, 0, 0, "resume_2");

    @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
